vid_rx_pack: RTL
================

Name: vid_rx_pack

Overview:
Downstream stage of the UDP receive path. Consumes the 16-bit RGB565 pixel stream (vid_vs/vid_de/vid_data) produced by the UDP receive buffer and packs 8 pixels into one 128-bit word for the frame-buffer write FIFO. It also tracks frame geometry, marks the first word of each frame and flags short, long or overflowed frames. Runs entirely in the app_rx_clk domain; the write FIFO performs the clock crossing.

Parameters:
H_ACT, 640, active pixels per line; must be a multiple of 8.
V_ACT, 480, active lines per frame.
OUT_W, 128, FIFO word width; fixed at 8 x 16 bits. Any other value is a build-time error.

Ports:
app_rx_clk  in  1  pixel/byte clock, 125 MHz.
rstn  in  1  reset, asynchronous, active-low.
vid_vs  in  1  one-cycle frame-start pulse.
vid_de  in  1  pixel valid; cannot be stalled.
vid_data  in  16  RGB565 pixel, valid when vid_de=1.
fifo_full  in  1  write FIFO full.
fifo_wr_en  out  1  write strobe.
fifo_wr_data  out  128  packed word; pixel 0 in [15:0], pixel 7 in [127:112].
fifo_wr_sof  out  1  qualifies fifo_wr_en; marks the first word of a frame.
frame_done  out  1  one-cycle pulse when the last word of a complete, clean frame is written.
frame_err  out  1  one-cycle pulse on short frame, long frame or overflow.
x_cnt  out  11  current pixel column (status).
y_cnt  out  10  current line (status).

Behaviour:
- Reset: all outputs 0; state IDLE; lane counter 0; sticky overflow flag 0.
- States:
  - IDLE: waits for vid_vs; vid_de is ignored.
  - ACTIVE: accepts pixels.
  - DONE: frame complete; any vid_de sets the long-frame error; waits for vid_vs.
- vid_vs in any state:
  - Clears x_cnt, y_cnt, lane counter and the overflow flag.
  - Arms sof_pending.
  - Enters ACTIVE.
  - If the previous state was ACTIVE (short frame): pulse frame_err next cycle and discard the partial word.
- vid_vs and vid_de in the same cycle: vs takes priority; the pixel is taken as pixel 0 of the new frame.
- Packing in ACTIVE, per vid_de:
  - vid_data is written to lane[lane_cnt]; lane_cnt increments and wraps 7 to 0.
  - x_cnt increments; at H_ACT-1 it wraps to 0 and y_cnt increments.
- Word completion on the 8th pixel (lane_cnt=7 with vid_de):
  - The next cycle outputs fifo_wr_en=1 with the 8 lanes on fifo_wr_data; latency is 1 cycle from the 8th pixel sample.
  - fifo_wr_sof=1 if sof_pending, which then clears.
  - fifo_wr_data holds its value between writes; it is not zeroed.
- Overflow (word ready while fifo_full=1):
  - fifo_wr_en stays 0 and the word is dropped.
  - The sticky overflow flag is set; the pixel count still advances.
  - If the dropped word carried SOF, sof_pending stays armed for the next word.
- Last pixel (x_cnt=H_ACT-1, y_cnt=V_ACT-1):
  - The final word is written as normal; the state goes to DONE.
  - Same cycle as that write: frame_done=1 if overflow=0, otherwise frame_err=1.
- Long frame: the first vid_de in DONE pulses frame_err once per frame. Extra pixels are never written.
- frame_done and frame_err are never asserted in the same cycle.
- Reset mid-frame: immediate return to IDLE; the partial word is lost; no pulses.

Decomposition:
- Shared package vid_rx_pkg:
  - PIX_W=16, PIX_PER_WORD=8, OUT_W=128.
  - State encodings: IDLE/ACTIVE/DONE, one-hot, 3 bits.
  - Default H_ACT/V_ACT.
- One natural sub-module: vid_pix_packer, the lane register plus lane counter that emits word_valid and word_data. The top level keeps the FSM, geometry counters, SOF and error logic.

Test Plan (H_ACT=16, V_ACT=2 for all):
1. Clean frame: vs, then 32 consecutive de with data=0x0000..0x001F, fifo_full=0.
   - Exactly 4 writes, each 1 cycle after pixels 7/15/23/31.
   - Word0 = {0x0007,...,0x0000}, with sof=1 on word0 only.
   - frame_done with word3; no frame_err.
2. Gapped de: same pixels with de toggling every other cycle.
   - Identical 4 words and values.
   - Each write 1 cycle after its 8th pixel.
3. Short frame: vs, 20 pixels, vs.
   - 2 words written; the partial word is never written.
   - frame_err pulse 1 cycle after the second vs.
   - The next 32 pixels yield 4 words, first with sof=1.
4. Overflow: fifo_full=1 during the cycle word1 is ready.
   - Word1 dropped; 3 writes total.
   - frame_err (not frame_done) with word3.
5. Long frame: 40 pixels after vs.
   - 4 words; frame_done with word3.
   - frame_err on pixel 33; pixels 33-40 not written.
6. Reset mid-frame: assert rstn=0 after pixel 5.
   - All outputs 0.
   - No write until the next vs plus 8 pixels, which gives sof=1.

Source files
------------

// File: rtl/vid_rx_pkg.sv
// Shared constants and types for the UDP receive pixel packer.
package vid_rx_pkg;

   localparam int PIX_W        = 16;
   localparam int PIX_PER_WORD = 8;
   localparam int OUT_W        = PIX_W * PIX_PER_WORD;

   localparam int H_ACT_DEF    = 640;
   localparam int V_ACT_DEF    = 480;

   // Frame tracking FSM, one-hot
   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_ACTIVE = 3'b010,
      ST_DONE   = 3'b100
   } state_t;

endpackage

// File: rtl/vid_pix_packer.sv
// Lane register and lane counter: gathers NUM_LANES pixels and presents one
// packed word the cycle after the last lane is sampled.
module vid_pix_packer
   import vid_rx_pkg::*;
#(
   parameter int NUM_LANES = PIX_PER_WORD,
   parameter int VEC_W     = PIX_W
) (
   input  logic                             app_rx_clk,
   input  logic                             rstn,
   input  logic                             i_clr,
   input  logic                             i_pix_vld,
   input  logic [VEC_W-1:0]                 i_pix,
   output logic                             o_word_valid,
   output logic [NUM_LANES-1:0][VEC_W-1:0]  o_word_data
);

   localparam int               CNT_W     = $clog2(NUM_LANES);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

   logic [CNT_W-1:0]                r_lane_cnt;
   logic [CNT_W-1:0]                w_lane_cur;
   logic                            w_word_done;
   logic [NUM_LANES-2:0][VEC_W-1:0] r_lane;
   logic [NUM_LANES-1:0][VEC_W-1:0] r_word;
   logic                            r_word_vld;

   // A clear drops any partial word; a pixel arriving with it lands in lane 0
   assign w_lane_cur  = i_clr ? '0 : r_lane_cnt;
   assign w_word_done = i_pix_vld && (w_lane_cur == LAST_LANE);

   // Lane pointer, advances per accepted pixel and wraps after the last lane
   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn)
         r_lane_cnt <= '0;
      else if (i_pix_vld)
         r_lane_cnt <= (w_lane_cur == LAST_LANE) ? '0 : w_lane_cur + 1'b1;
      else
         r_lane_cnt <= w_lane_cur;
   end

   // Capture lanes 0..N-2; the final lane goes straight into the word register
   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn)
         r_lane <= '0;
      else if (i_pix_vld) begin
         for (int l = 0; l < NUM_LANES - 1; l++)
            if (w_lane_cur == CNT_W'(l))
               r_lane[l] <= i_pix;
      end
   end

   // Word register holds its contents between words so the FIFO data bus is stable
   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn) begin
         r_word     <= '0;
         r_word_vld <= 1'b0;
      end else begin
         r_word_vld <= w_word_done;
         if (w_word_done) begin
            r_word[NUM_LANES-2:0] <= r_lane;
            r_word[NUM_LANES-1]   <= i_pix;
         end
      end
   end

   assign o_word_valid = r_word_vld;
   assign o_word_data  = r_word;

endmodule

// File: rtl/vid_rx_pack.sv
// RGB565 stream to 128-bit FIFO word packer with frame geometry tracking,
// start-of-frame marking and short/long/overflow frame reporting.
module vid_rx_pack
   import vid_rx_pkg::*;
#(
   parameter int H_ACT = H_ACT_DEF,
   parameter int V_ACT = V_ACT_DEF,
   parameter int OUT_W = vid_rx_pkg::OUT_W
) (
   input  logic              app_rx_clk,
   input  logic              rstn,
   input  logic              vid_vs,
   input  logic              vid_de,
   input  logic [PIX_W-1:0]  vid_data,
   input  logic              fifo_full,
   output logic              fifo_wr_en,
   output logic [OUT_W-1:0]  fifo_wr_data,
   output logic              fifo_wr_sof,
   output logic              frame_done,
   output logic              frame_err,
   output logic [10:0]       x_cnt,
   output logic [9:0]        y_cnt
);

   generate
      if (OUT_W != PIX_W * PIX_PER_WORD) begin : g_bad_out_w
         $error("vid_rx_pack: OUT_W must equal 8 x 16 bits");
      end
      if ((H_ACT % PIX_PER_WORD) != 0) begin : g_bad_h_act
         $error("vid_rx_pack: H_ACT must be a multiple of 8");
      end
   endgenerate

   localparam logic [10:0] X_LAST = 11'(H_ACT - 1);
   localparam logic [9:0]  Y_LAST = 10'(V_ACT - 1);

   state_t        r_state, w_state_nxt;
   logic [10:0]   r_x_cnt, w_x_cur, w_x_nxt;
   logic [9:0]    r_y_cnt, w_y_cur, w_y_nxt;
   logic          r_sof_pend;
   logic          r_ovf;
   logic          r_last_pend;
   logic          r_err_pend;
   logic          r_long_seen;

   logic          w_accept;
   logic          w_last_pix;
   logic          w_short;
   logic          w_long;
   logic          w_word_vld;
   logic          w_ovf_now;
   logic          w_ovf_any;
   logic [PIX_PER_WORD-1:0][PIX_W-1:0] w_word_data;

   // Pixels count in ACTIVE, and also alongside vs since that pixel opens the new frame
   assign w_accept   = vid_de && (vid_vs || (r_state == ST_ACTIVE));
   assign w_x_cur    = vid_vs ? '0 : r_x_cnt;
   assign w_y_cur    = vid_vs ? '0 : r_y_cnt;
   assign w_last_pix = w_accept && (w_x_cur == X_LAST) && (w_y_cur == Y_LAST);
   assign w_short    = vid_vs && (r_state == ST_ACTIVE);
   assign w_long     = !vid_vs && vid_de && (r_state == ST_DONE) && !r_long_seen;

   vid_pix_packer #(
      .NUM_LANES (PIX_PER_WORD),
      .VEC_W     (PIX_W)
   ) u_packer (
      .app_rx_clk   (app_rx_clk),
      .rstn         (rstn),
      .i_clr        (vid_vs),
      .i_pix_vld    (w_accept),
      .i_pix        (vid_data),
      .o_word_valid (w_word_vld),
      .o_word_data  (w_word_data)
   );

   // State register
   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state: vs restarts from any state, the last pixel ends the frame
   always_comb begin
      w_state_nxt = r_state;
      if (vid_vs)
         w_state_nxt = ST_ACTIVE;
      else begin
         case (r_state)
            ST_ACTIVE: if (w_last_pix) w_state_nxt = ST_DONE;
            default:   w_state_nxt = r_state;
         endcase
      end
   end

   // Next column/line for the accepted pixel; the line counter wraps after the frame
   always_comb begin
      w_x_nxt = w_x_cur;
      w_y_nxt = w_y_cur;
      if (w_accept) begin
         if (w_x_cur == X_LAST) begin
            w_x_nxt = '0;
            w_y_nxt = (w_y_cur == Y_LAST) ? '0 : w_y_cur + 1'b1;
         end else
            w_x_nxt = w_x_cur + 1'b1;
      end
   end

   // Geometry counters
   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn) begin
         r_x_cnt <= '0;
         r_y_cnt <= '0;
      end else begin
         r_x_cnt <= w_x_nxt;
         r_y_cnt <= w_y_nxt;
      end
   end

   // SOF stays armed until a word actually reaches the FIFO; vs re-arms it
   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn)
         r_sof_pend <= 1'b0;
      else if (vid_vs)
         r_sof_pend <= 1'b1;
      else if (fifo_wr_en)
         r_sof_pend <= 1'b0;
   end

   // Sticky per-frame overflow flag plus end-of-frame and error pulse staging
   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn) begin
         r_ovf       <= 1'b0;
         r_last_pend <= 1'b0;
         r_err_pend  <= 1'b0;
         r_long_seen <= 1'b0;
      end else begin
         r_last_pend <= w_last_pix;
         r_err_pend  <= w_short || w_long;
         if (vid_vs) begin
            r_ovf       <= 1'b0;
            r_long_seen <= 1'b0;
         end else begin
            if (w_ovf_now) r_ovf       <= 1'b1;
            if (w_long)    r_long_seen <= 1'b1;
         end
      end
   end

   // A word is dropped rather than written when the FIFO is full in its output cycle
   assign w_ovf_now    = w_word_vld && fifo_full;
   assign w_ovf_any    = r_ovf || w_ovf_now;
   assign fifo_wr_en   = w_word_vld && !fifo_full;
   assign fifo_wr_sof  = fifo_wr_en && r_sof_pend;
   assign fifo_wr_data = w_word_data;
   assign frame_err    = r_err_pend || (r_last_pend && w_ovf_any);
   assign frame_done   = r_last_pend && !w_ovf_any && !r_err_pend;
   assign x_cnt        = r_x_cnt;
   assign y_cnt        = r_y_cnt;

endmodule
